// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot/run sequencer.
package mips_boot_pkg;

    // Top-level sequencer states
    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        LOAD_D,
        RUN,
        HALT
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    // Memory select encoding on mem_sel
    localparam logic SEL_IMEM = 1'b0;
    localparam logic SEL_DMEM = 1'b1;

endpackage

// File: rtl/mips_boot_ctrl_serializer.sv
// Turns one accepted 32-bit word into four consecutive little-endian byte
// writes. A word that would run past the end of memory still occupies the
// four slots but its write strobe is suppressed.
module word_byte_serializer
    import mips_boot_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [31:0]       data,
    input  logic              last,
    input  logic [ADDR_W:0]   base,
    output logic              fits,
    output logic              busy,
    output logic              last_byte,
    output logic              last_word,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata
);

    localparam int MEM_BYTES = 1 << ADDR_W;

    logic [1:0]        idx;
    logic [23:0]       rest;
    logic              we_en;
    logic [ADDR_W+1:0] end_addr;

    assign end_addr  = {1'b0, base} + (ADDR_W+2)'(BYTES_PER_WORD);
    assign fits      = end_addr <= (ADDR_W+2)'(MEM_BYTES);
    assign last_byte = busy && (idx == 2'd3);

    // Byte sequencing: load byte 0 on acceptance, then step through bytes 1..3
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            idx       <= 2'd0;
            rest      <= '0;
            we_en     <= 1'b0;
            last_word <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (load) begin
            busy      <= 1'b1;
            idx       <= 2'd0;
            rest      <= data[31:8];
            we_en     <= fits;
            last_word <= last;
            mem_we    <= fits;
            mem_addr  <= base[ADDR_W-1:0];
            mem_wdata <= data[7:0];
        end else if (busy && (idx != 2'd3)) begin
            idx       <= idx + 2'd1;
            rest      <= {8'h00, rest[23:8]};
            mem_we    <= we_en;
            mem_addr  <= mem_addr + 1'b1;
            mem_wdata <= rest[7:0];
        end else begin
            busy      <= 1'b0;
            idx       <= 2'd0;
            we_en     <= 1'b0;
            last_word <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

endmodule

// File: rtl/mips_boot_ctrl.sv
// Boot/run sequencer: loads instruction then data memory from a word stream,
// runs the core until it reaches halt_pc or a cycle budget, then parks it.
module mips_boot_ctrl
    import mips_boot_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int CYC_W      = 24,
    parameter int MAX_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              cpu_run,
    input  logic [31:0]       cpu_pc,
    input  logic [31:0]       halt_pc,
    output logic              done,
    output logic              timeout,
    output logic              overflow,
    output logic [CYC_W-1:0]  run_cycles
);

    state_t          state;
    logic [ADDR_W:0] base;
    logic            loading;
    logic            accept;
    logic            fits;
    logic            busy;
    logic            last_byte;
    logic            last_word;

    // A new word may enter while idle or during byte 3 of a non-final word,
    // which keeps back-to-back words at one per four cycles.
    assign loading  = (state == LOAD_I) || (state == LOAD_D);
    assign in_ready = loading && (!busy || (last_byte && !last_word));
    assign accept   = in_valid && in_ready;

    word_byte_serializer #(
        .ADDR_W(ADDR_W)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .data      (in_data),
        .last      (in_last),
        .base      (base),
        .fits      (fits),
        .busy      (busy),
        .last_byte (last_byte),
        .last_word (last_word),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    // Sequencer FSM with registered core controls, status flags and cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            mem_sel    <= SEL_IMEM;
            cpu_rst    <= 1'b1;
            cpu_run    <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            overflow   <= 1'b0;
            run_cycles <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state      <= LOAD_I;
                        base       <= '0;
                        mem_sel    <= SEL_IMEM;
                        cpu_rst    <= 1'b1;
                        cpu_run    <= 1'b0;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                        overflow   <= 1'b0;
                        run_cycles <= '0;
                    end
                end
                LOAD_I, LOAD_D: begin
                    if (accept) begin
                        if (fits) begin
                            base <= base + (ADDR_W+1)'(BYTES_PER_WORD);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    if (last_byte && last_word) begin
                        base <= '0;
                        if (state == LOAD_I) begin
                            state   <= LOAD_D;
                            mem_sel <= SEL_DMEM;
                        end else begin
                            state   <= RUN;
                            cpu_rst <= 1'b0;
                            cpu_run <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (run_cycles != '1) begin
                        run_cycles <= run_cycles + 1'b1;
                    end
                    if (cpu_pc == halt_pc) begin
                        state   <= HALT;
                        cpu_run <= 1'b0;
                        done    <= 1'b1;
                    end else if (run_cycles == CYC_W'(MAX_CYCLES - 1)) begin
                        state   <= HALT;
                        cpu_run <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Directed self-checking bench for mips_boot_ctrl (8-byte memories, 16-cycle budget).
module tb_mips_boot_ctrl;

    localparam int AW = 3;
    localparam int CW = 24;

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_last;
    logic          mem_we;
    logic          mem_sel;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          cpu_rst;
    logic          cpu_run;
    logic [31:0]   cpu_pc;
    logic [31:0]   halt_pc;
    logic          done;
    logic          timeout;
    logic          overflow;
    logic [CW-1:0] run_cycles;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;

    logic [7:0] imem_m [8];
    logic [7:0] dmem_m [8];

    mips_boot_ctrl #(
        .ADDR_W     (AW),
        .CYC_W      (CW),
        .MAX_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .mem_we     (mem_we),
        .mem_sel    (mem_sel),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst    (cpu_rst),
        .cpu_run    (cpu_run),
        .cpu_pc     (cpu_pc),
        .halt_pc    (halt_pc),
        .done       (done),
        .timeout    (timeout),
        .overflow   (overflow),
        .run_cycles (run_cycles)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte-wide memory model capturing every strobed write
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            if (mem_sel) dmem_m[mem_addr] <= mem_wdata;
            else         imem_m[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    // Absolute watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] data, input logic last, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        t = 0;
        while (in_ready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL handshake: in_ready=%b, required 1 within 20 cycles", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic watch_word(input logic [31:0] data, input logic [AW-1:0] base,
                              input logic sel, input logic we_exp, input logic ready_end,
                              input string name);
        logic [7:0] b;
        logic       rdy;
        for (int i = 0; i < 4; i++) begin
            b   = data[8*i +: 8];
            rdy = (i == 3) ? ready_end : 1'b0;
            checks++;
            if (mem_we !== we_exp) begin
                errors++;
                $display("[TB] FAIL %s we[%0d]: got %b required %b", name, i, mem_we, we_exp);
            end
            if (we_exp) begin
                checks++;
                if (mem_addr !== AW'(base + i) || mem_wdata !== b || mem_sel !== sel) begin
                    errors++;
                    $display("[TB] FAIL %s byte[%0d]: got sel=%b addr=%0d data=%h required sel=%b addr=%0d data=%h",
                             name, i, mem_sel, mem_addr, mem_wdata, sel, AW'(base + i), b);
                end
            end
            checks++;
            if (in_ready !== rdy) begin
                errors++;
                $display("[TB] FAIL %s ready[%0d]: got %b required %b", name, i, in_ready, rdy);
            end
            if (i < 3) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, mem_we, mem_sel, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mem: got ready=%b we=%b sel=%b addr=%0d data=%h required all 0",
                     in_ready, mem_we, mem_sel, mem_addr, mem_wdata);
        end
        checks++;
        if (cpu_rst !== 1'b1 || cpu_run !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_cpu: got cpu_rst=%b cpu_run=%b required 1/0", cpu_rst, cpu_run);
        end
        checks++;
        if ({done, timeout, overflow} !== 3'b000 || run_cycles !== '0) begin
            errors++;
            $display("[TB] FAIL reset_status: got done=%b timeout=%b overflow=%b cycles=%0d required 0",
                     done, timeout, overflow, run_cycles);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_ready: got %b required 0", in_ready);
        end
    endtask

    task automatic test_load();
        logic [7:0] exp_i [8];
        logic [7:0] exp_d [4];
        exp_i = '{8'h05, 8'h00, 8'h08, 8'h20, 8'h0A, 8'h00, 8'h09, 8'h20};
        exp_d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        cpu_pc  = 32'h0;
        halt_pc = 32'h28;
        pulse_start();
        send_word(32'h20080005, 1'b0, 0);
        watch_word(32'h20080005, 3'd0, 1'b0, 1'b1, 1'b1, "imem_w0");
        send_word(32'h2009000A, 1'b1, 0);
        watch_word(32'h2009000A, 3'd4, 1'b0, 1'b1, 1'b0, "imem_w1");
        @(posedge clk); #1;
        checks++;
        if (mem_sel !== 1'b1 || in_ready !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_dmem: got sel=%b ready=%b we=%b required 1/1/0", mem_sel, in_ready, mem_we);
        end
        send_word(32'hDEADBEEF, 1'b1, 0);
        watch_word(32'hDEADBEEF, 3'd0, 1'b1, 1'b1, 1'b0, "dmem_w0");
        @(posedge clk); #1;
        checks++;
        if (cpu_rst !== 1'b0 || cpu_run !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL enter_run: got cpu_rst=%b cpu_run=%b ready=%b required 0/1/0", cpu_rst, cpu_run, in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (imem_m[i] !== exp_i[i]) begin
                errors++;
                $display("[TB] FAIL imem[%0d]: got %h required %h", i, imem_m[i], exp_i[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dmem_m[i] !== exp_d[i]) begin
                errors++;
                $display("[TB] FAIL dmem[%0d]: got %h required %h", i, dmem_m[i], exp_d[i]);
            end
        end
        checks++;
        if (wr_count !== 12) begin
            errors++;
            $display("[TB] FAIL write_count: got %0d required 12", wr_count);
        end
    endtask

    task automatic test_halt();
        int k = 0;
        while (done !== 1'b1 && k < 30) begin
            cpu_pc = 32'(4 * k);
            start  = (k == 3);
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        checks++;
        if (k !== 11) begin
            errors++;
            $display("[TB] FAIL halt_latency: done after %0d RUN cycles, required 11", k);
        end
        checks++;
        if (done !== 1'b1 || cpu_run !== 1'b0 || cpu_rst !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL halt_state: got done=%b run=%b cpu_rst=%b timeout=%b required 1/0/0/0",
                     done, cpu_run, cpu_rst, timeout);
        end
        checks++;
        if (run_cycles !== 24'd11) begin
            errors++;
            $display("[TB] FAIL halt_cycles: got %0d required 11", run_cycles);
        end
        checks++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL halt_quiet: got ready=%b we=%b required 0/0", in_ready, mem_we);
        end
    endtask

    task automatic test_timeout_gaps();
        int n = 0;
        int snap;
        cpu_pc = 32'h100;
        pulse_start();
        checks++;
        if (done !== 1'b0 || run_cycles !== '0 || cpu_rst !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_clear: got done=%b cycles=%0d cpu_rst=%b required 0/0/1", done, run_cycles, cpu_rst);
        end
        snap = wr_count;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (wr_count !== snap || mem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gap_writes: got %0d writes required 0", wr_count - snap);
        end
        send_word(32'h11223344, 1'b1, 2);
        watch_word(32'h11223344, 3'd0, 1'b0, 1'b1, 1'b0, "gap_imem");
        send_word(32'h55667788, 1'b1, 3);
        watch_word(32'h55667788, 3'd0, 1'b1, 1'b1, 1'b0, "gap_dmem");
        @(posedge clk); #1;
        checks++;
        if (cpu_run !== 1'b1) begin
            errors++;
            $display("[TB] FAIL to_run2: got cpu_run=%b required 1", cpu_run);
        end
        while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== 16 || timeout !== 1'b1 || run_cycles !== 24'd16) begin
            errors++;
            $display("[TB] FAIL timeout: got cycles_seen=%0d timeout=%b run_cycles=%0d required 16/1/16", n, timeout, run_cycles);
        end
        checks++;
        if ({imem_m[3], imem_m[2], imem_m[1], imem_m[0]} !== 32'h11223344 ||
            {dmem_m[3], dmem_m[2], dmem_m[1], dmem_m[0]} !== 32'h55667788) begin
            errors++;
            $display("[TB] FAIL gap_order: got imem=%h dmem=%h required 11223344/55667788",
                     {imem_m[3], imem_m[2], imem_m[1], imem_m[0]}, {dmem_m[3], dmem_m[2], dmem_m[1], dmem_m[0]});
        end
    endtask

    task automatic test_overflow();
        int snap;
        pulse_start();
        checks++;
        if (timeout !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_flags: got timeout=%b overflow=%b required 0/0", timeout, overflow);
        end
        snap = wr_count;
        send_word(32'hA1A2A3A4, 1'b0, 0);
        watch_word(32'hA1A2A3A4, 3'd0, 1'b0, 1'b1, 1'b1, "ovf_w0");
        send_word(32'hB1B2B3B4, 1'b0, 0);
        watch_word(32'hB1B2B3B4, 3'd4, 1'b0, 1'b1, 1'b1, "ovf_w1");
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_early: got %b required 0", overflow);
        end
        send_word(32'hC1C2C3C4, 1'b1, 0);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_set: got %b required 1", overflow);
        end
        watch_word(32'hC1C2C3C4, 3'd0, 1'b0, 1'b0, 1'b0, "ovf_w2");
        checks++;
        if (wr_count - snap !== 8 || imem_m[0] !== 8'hA4 || imem_m[7] !== 8'hB1) begin
            errors++;
            $display("[TB] FAIL ovf_writes: got %0d writes imem0=%h imem7=%h required 8/a4/b1",
                     wr_count - snap, imem_m[0], imem_m[7]);
        end
        @(posedge clk); #1;
        cpu_pc = halt_pc;
        send_word(32'h0BADF00D, 1'b1, 0);
        watch_word(32'h0BADF00D, 3'd0, 1'b1, 1'b1, 1'b0, "ovf_dmem");
        @(posedge clk); #1;
        checks++;
        if (cpu_run !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_continue: got run=%b overflow=%b required 1/1", cpu_run, overflow);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || run_cycles !== 24'd1 || timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_halt: got done=%b cycles=%0d timeout=%b required 1/1/0", done, run_cycles, timeout);
        end
    endtask

    task automatic test_reset_mid();
        int snap;
        pulse_start();
        send_word(32'hCAFEF00D, 1'b0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 8'hFE || mem_addr !== 3'd2) begin
            errors++;
            $display("[TB] FAIL mid_byte2: got we=%b addr=%0d data=%h required 1/2/fe", mem_we, mem_addr, mem_wdata);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || cpu_rst !== 1'b1 || in_ready !== 1'b0 || cpu_run !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got we=%b cpu_rst=%b ready=%b run=%b required 0/1/0/0",
                     mem_we, cpu_rst, in_ready, cpu_run);
        end
        snap = wr_count;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (wr_count !== snap || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_idle: got %0d writes ready=%b required 0/0", wr_count - snap, in_ready);
        end
        cpu_pc = halt_pc;
        pulse_start();
        send_word(32'h01020304, 1'b1, 1);
        watch_word(32'h01020304, 3'd0, 1'b0, 1'b1, 1'b0, "reload_imem");
        send_word(32'h0A0B0C0D, 1'b1, 1);
        watch_word(32'h0A0B0C0D, 3'd0, 1'b1, 1'b1, 1'b0, "reload_dmem");
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || {imem_m[3], imem_m[2], imem_m[1], imem_m[0]} !== 32'h01020304) begin
            errors++;
            $display("[TB] FAIL reload: got done=%b imem=%h required 1/01020304",
                     done, {imem_m[3], imem_m[2], imem_m[1], imem_m[0]});
        end
    endtask

    // Scenario sequence
    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        cpu_pc   = '0;
        halt_pc  = 32'h28;
        for (int i = 0; i < 8; i++) begin
            imem_m[i] = '0;
            dmem_m[i] = '0;
        end
        test_reset();
        test_load();
        test_halt();
        test_timeout_gaps();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
